// File: rtl/full_st1_tap_ctrl.sv
// Tap-memory sequencer: load, row read, interleaved read and per-lane
// update of a 16-row x 192-bit (6 x 32-bit lane) tap store.
//
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   cmd_vld/op/rdy       : command handshake (0 LOAD,1 READ,2 READT,3 UPDATE)
//   in_vld/data/rdy      : full-row load stream
//   upd_vld/data/rdy     : single-word update stream
//   tap_*                : bank controls (read, row write, lane write, interleave)
//   tap_rd_data          : bank read data, one cycle after tap_rd_vld
//   out_vld/data/last    : read return stream (no backpressure)
//   done                 : one-cycle completion pulse
module full_st1_tap_ctrl #(
  parameter int NUM_ROWS  = 6,
  parameter int NUM_LANES = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_vld,
  input  logic [1:0]   cmd_op,
  output logic         cmd_rdy,
  input  logic         in_vld,
  input  logic [191:0] in_data,
  output logic         in_rdy,
  input  logic         upd_vld,
  input  logic [31:0]  upd_data,
  output logic         upd_rdy,
  output logic [3:0]   tap_rd_address,
  output logic         tap_rd_vld,
  output logic [3:0]   tap_wr_address,
  output logic         tap_wr_vld,
  output logic [191:0] tap_wr_data,
  output logic [2:0]   tap_sub_addr,
  output logic [31:0]  tap_sub_data,
  output logic         tap_sub_vld,
  output logic         tap_inter,
  output logic         tap_inter_first,
  input  logic [191:0] tap_rd_data,
  output logic         out_vld,
  output logic [191:0] out_data,
  output logic         out_last,
  output logic         done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_READT = 3'd3;
  localparam logic [2:0] S_UPD   = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;

  localparam logic [3:0] LAST_ROW  = 4'(NUM_ROWS - 1);
  localparam logic [2:0] LAST_LANE = 3'(NUM_LANES - 1);

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic [3:0] r_row;
  logic [3:0] w_row_nxt;
  logic [2:0] r_lane;
  logic [2:0] w_lane_nxt;
  logic       r_out_vld;
  logic       r_out_last;
  logic       r_done;

  logic w_ld_acc;
  logic w_up_acc;
  logic w_rd_iss;
  logic w_last_row;
  logic w_last_lane;
  logic w_fin;

  assign w_last_row  = (r_row == LAST_ROW);
  assign w_last_lane = (r_lane == LAST_LANE);
  assign w_ld_acc    = (r_state == S_LOAD) & in_vld;
  assign w_up_acc    = (r_state == S_UPD) & upd_vld;
  assign w_rd_iss    = (r_state == S_READ) | (r_state == S_READT);

  // Final beat of any command; done follows one cycle later, which for
  // reads lands in the DRAIN cycle together with out_last.
  assign w_fin = (w_ld_acc & w_last_row)
               | (w_up_acc & w_last_row & w_last_lane)
               | (w_rd_iss & w_last_row);

  always_comb begin
    w_next     = r_state;
    w_row_nxt  = r_row;
    w_lane_nxt = r_lane;
    unique case (r_state)
      S_IDLE: begin
        if (cmd_vld) begin
          w_row_nxt  = 4'd0;
          w_lane_nxt = 3'd0;
          unique case (cmd_op)
            2'd0: w_next = S_LOAD;
            2'd1: w_next = S_READ;
            2'd2: w_next = S_READT;
            2'd3: w_next = S_UPD;
            default: w_next = S_IDLE;
          endcase
        end
      end
      S_LOAD: begin
        if (in_vld) begin
          w_row_nxt = r_row + 4'd1;
          if (w_last_row) w_next = S_IDLE;
        end
      end
      S_READ, S_READT: begin
        w_row_nxt = r_row + 4'd1;
        if (w_last_row) w_next = S_DRAIN;
      end
      S_UPD: begin
        if (upd_vld) begin
          if (w_last_lane) begin
            w_lane_nxt = 3'd0;
            w_row_nxt  = r_row + 4'd1;
            if (w_last_row) w_next = S_IDLE;
          end else begin
            w_lane_nxt = r_lane + 3'd1;
          end
        end
      end
      S_DRAIN: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_row      <= 4'd0;
      r_lane     <= 3'd0;
      r_out_vld  <= 1'b0;
      r_out_last <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_row      <= w_row_nxt;
      r_lane     <= w_lane_nxt;
      r_out_vld  <= w_rd_iss;
      r_out_last <= w_rd_iss & w_last_row;
      r_done     <= w_fin;
    end
  end

  assign cmd_rdy = (r_state == S_IDLE);
  assign in_rdy  = (r_state == S_LOAD);
  assign upd_rdy = (r_state == S_UPD);

  // Interleaved reads present row 0 only; the bank rotates the rest.
  assign tap_rd_vld      = w_rd_iss;
  assign tap_rd_address  = (r_state == S_READ) ? r_row : 4'd0;
  assign tap_inter       = (r_state == S_READT);
  assign tap_inter_first = (r_state == S_READT) & (r_row == 4'd0);

  assign tap_wr_vld     = w_ld_acc;
  assign tap_wr_address = (w_ld_acc | w_up_acc) ? r_row : 4'd0;
  assign tap_wr_data    = w_ld_acc ? in_data : 192'd0;
  assign tap_sub_vld    = w_up_acc;
  assign tap_sub_addr   = w_up_acc ? r_lane : 3'd0;
  assign tap_sub_data   = w_up_acc ? upd_data : 32'd0;

  assign out_vld  = r_out_vld;
  assign out_last = r_out_last;
  assign out_data = r_out_vld ? tap_rd_data : 192'd0;
  assign done     = r_done;

endmodule

// File: tb/tb_full_st1_tap_ctrl.sv
// Bench for full_st1_tap_ctrl: bank model, shadow tap store,
// table of command vectors, hand corner cases and random traffic.
module tb_full_st1_tap_ctrl;

  localparam int NR = 6;
  localparam logic [1:0] OP_LD  = 2'd0;
  localparam logic [1:0] OP_RD  = 2'd1;
  localparam logic [1:0] OP_RDT = 2'd2;
  localparam logic [1:0] OP_UP  = 2'd3;
  localparam logic [191:0] PAT = {6{32'h5A5A_C3C3}};

  logic         clk;
  logic         reset;
  logic         cmd_vld;
  logic [1:0]   cmd_op;
  logic         cmd_rdy;
  logic         in_vld;
  logic [191:0] in_data;
  logic         in_rdy;
  logic         upd_vld;
  logic [31:0]  upd_data;
  logic         upd_rdy;
  logic [3:0]   tap_rd_address;
  logic         tap_rd_vld;
  logic [3:0]   tap_wr_address;
  logic         tap_wr_vld;
  logic [191:0] tap_wr_data;
  logic [2:0]   tap_sub_addr;
  logic [31:0]  tap_sub_data;
  logic         tap_sub_vld;
  logic         tap_inter;
  logic         tap_inter_first;
  logic [191:0] tap_rd_data;
  logic         out_vld;
  logic [191:0] out_data;
  logic         out_last;
  logic         done;

  full_st1_tap_ctrl #(.NUM_ROWS(NR), .NUM_LANES(6)) dut (
    .clk(clk), .reset(reset),
    .cmd_vld(cmd_vld), .cmd_op(cmd_op), .cmd_rdy(cmd_rdy),
    .in_vld(in_vld), .in_data(in_data), .in_rdy(in_rdy),
    .upd_vld(upd_vld), .upd_data(upd_data), .upd_rdy(upd_rdy),
    .tap_rd_address(tap_rd_address), .tap_rd_vld(tap_rd_vld),
    .tap_wr_address(tap_wr_address), .tap_wr_vld(tap_wr_vld),
    .tap_wr_data(tap_wr_data), .tap_sub_addr(tap_sub_addr),
    .tap_sub_data(tap_sub_data), .tap_sub_vld(tap_sub_vld),
    .tap_inter(tap_inter), .tap_inter_first(tap_inter_first),
    .tap_rd_data(tap_rd_data),
    .out_vld(out_vld), .out_data(out_data), .out_last(out_last),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank model: row/lane writes, registered reads, interleave returns
  // row k xor PAT on beat k.
  logic [191:0] bmem [16];
  logic [191:0] bdata = '0;
  logic [3:0]   bib = '0;
  assign tap_rd_data = bdata;

  always @(posedge clk) begin
    if (tap_wr_vld) bmem[tap_wr_address] <= tap_wr_data;
    if (tap_sub_vld)
      bmem[tap_wr_address][tap_sub_addr*32 +: 32] <= tap_sub_data;
    if (tap_rd_vld) begin
      if (tap_inter) begin
        bib   <= tap_inter_first ? 4'd1 : bib + 4'd1;
        bdata <= bmem[tap_inter_first ? 4'd0 : bib] ^ PAT;
      end else begin
        bdata <= bmem[tap_rd_address];
      end
    end
  end

  // Shadow of the tap store built only from what the bench sent.
  logic [191:0] shadow [NR];

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [191:0] act,
                     input logic [191:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic bit vpat(input int mode, input int n);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (n % 2) == 0;
    return $urandom_range(0, 1) == 1;
  endfunction

  function automatic logic [191:0] rnd192();
    return {$urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom()};
  endfunction

  // Runs one command; cycle 0 presents it (unless already accepted),
  // cycle n>=1 counts from the acceptance edge. Returns the done cycle.
  task automatic run_cmd(input logic [1:0] op, input int mode,
                         input bit hold, input bit pre,
                         output int dcyc, output int nwr, output int nsub,
                         output int nrd, output int nout);
    int k, ob, n, tot;
    bit pr, pr_n, fin, fn, stop;
    logic [191:0] exp;
    k = 0; ob = 0; pr = 0; fin = 0; stop = 0; dcyc = -1;
    nwr = 0; nsub = 0; nrd = 0; nout = 0;
    tot = (op == OP_UP) ? NR * 6 : NR;
    if (!pre) begin
      cmd_vld = 1'b1; cmd_op = op; in_vld = 1'b0; upd_vld = 1'b0;
      @(negedge clk);
      chk("cmd_rdy_idle", cmd_rdy, 1);
      chk("idle_bank", {tap_rd_vld, tap_wr_vld, tap_sub_vld, tap_inter}, 0);
      @(posedge clk); #1;
    end
    cmd_vld = hold;
    cmd_op  = OP_RD;
    n = 1;
    while (!stop && n < 200) begin
      in_vld   = vpat(mode, n);
      upd_vld  = vpat(mode, n);
      in_data  = rnd192();
      upd_data = $urandom();
      fn = fin; pr_n = 1'b0;
      @(negedge clk);
      nwr  += int'(tap_wr_vld);
      nsub += int'(tap_sub_vld);
      nrd  += int'(tap_rd_vld);
      nout += int'(out_vld);
      if (pr) begin
        exp = (op == OP_RDT) ? (shadow[ob] ^ PAT) : shadow[ob];
        chk("out_vld", out_vld, 1);
        chk("out_data", out_data, exp);
        chk("out_last", out_last, ob == NR - 1);
        ob++;
      end else begin
        chk("out_quiet", {out_vld, out_last}, 0);
      end
      if (fin || done) begin
        chk("done", done, fin);
        if (fin) dcyc = n;
        stop = 1'b1;
      end else begin
        chk("cmd_rdy_busy", cmd_rdy, 0);
        if (op == OP_LD) begin
          chk("in_rdy", in_rdy, 1);
          chk("ld_wr_vld", tap_wr_vld, in_vld);
          chk("ld_sub_vld", tap_sub_vld, 0);
          if (in_vld) begin
            chk("ld_addr", tap_wr_address, k);
            chk("ld_data", tap_wr_data, in_data);
            shadow[k] = in_data;
            k++;
            if (k == tot) fn = 1'b1;
          end
        end else if (op == OP_UP) begin
          chk("upd_rdy", upd_rdy, 1);
          chk("up_sub_vld", tap_sub_vld, upd_vld);
          chk("up_wr_vld", tap_wr_vld, 0);
          if (upd_vld) begin
            chk("up_lane", tap_sub_addr, k % 6);
            chk("up_row", tap_wr_address, k / 6);
            chk("up_data", tap_sub_data, upd_data);
            shadow[k / 6][(k % 6) * 32 +: 32] = upd_data;
            k++;
            if (k == tot) fn = 1'b1;
          end
        end else begin
          chk("rd_vld", tap_rd_vld, 1);
          chk("rd_inter", tap_inter, op == OP_RDT);
          if (op == OP_RD) chk("rd_addr", tap_rd_address, k);
          if (op == OP_RDT) begin
            chk("rdt_first", tap_inter_first, k == 0);
            if (k == 0) chk("rdt_addr0", tap_rd_address, 0);
          end
          pr_n = 1'b1;
          k++;
          if (k == tot) fn = 1'b1;
        end
      end
      pr = pr_n;
      fin = fn;
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", dcyc > 0, 1);
    cmd_vld = 1'b0; in_vld = 1'b0; upd_vld = 1'b0;
  endtask

  typedef struct {
    logic [1:0] op;
    int mode;
    int dcyc;
    int nwr;
    int nsub;
    int nrd;
    int nout;
  } vec_t;

  vec_t tbl [8];
  int d, w, s, r, o;

  initial begin
    tbl[0] = '{OP_LD,  0,  7, 6,  0, 0, 0};
    tbl[1] = '{OP_RD,  0,  7, 0,  0, 6, 6};
    tbl[2] = '{OP_RDT, 0,  7, 0,  0, 6, 6};
    tbl[3] = '{OP_UP,  1, 73, 0, 36, 0, 0};
    tbl[4] = '{OP_RD,  0,  7, 0,  0, 6, 6};
    tbl[5] = '{OP_LD,  1, 13, 6,  0, 0, 0};
    tbl[6] = '{OP_UP,  0, 37, 0, 36, 0, 0};
    tbl[7] = '{OP_RDT, 0,  7, 0,  0, 6, 6};

    reset = 1'b1; cmd_vld = 1'b0; cmd_op = 2'd0;
    in_vld = 1'b0; in_data = '0; upd_vld = 1'b0; upd_data = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_valids",
        {in_rdy, upd_rdy, tap_rd_vld, tap_wr_vld, tap_sub_vld,
         tap_inter, tap_inter_first, out_vld, out_last, done}, 0);
    chk("rst_addr", {tap_rd_address, tap_wr_address, tap_sub_addr}, 0);
    chk("rst_wdata", tap_wr_data, 0);
    chk("rst_sdata", tap_sub_data, 0);
    chk("rst_odata", out_data, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_cmd_rdy", cmd_rdy, 1);
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_cmd(tbl[i].op, tbl[i].mode, 1'b0, 1'b0, d, w, s, r, o);
      chk("vec_done_cyc", d, tbl[i].dcyc);
      chk("vec_nwr", w, tbl[i].nwr);
      chk("vec_nsub", s, tbl[i].nsub);
      chk("vec_nrd", r, tbl[i].nrd);
      chk("vec_nout", o, tbl[i].nout);
    end

    // Reset on the third READ cycle aborts without done or out_vld.
    cmd_vld = 1'b1; cmd_op = OP_RD;
    @(posedge clk); #1;
    cmd_vld = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_rd_addr", tap_rd_address, 2);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_quiet",
          {out_vld, out_last, done, tap_rd_vld, tap_inter}, 0);
      chk("abort_cmd_rdy", cmd_rdy, 1);
      @(posedge clk); #1;
    end
    run_cmd(OP_RD, 0, 1'b0, 1'b0, d, w, s, r, o);
    chk("post_abort_done", d, 7);

    // cmd_vld held through UPDATE: READ taken only at the done cycle.
    run_cmd(OP_UP, 1, 1'b1, 1'b0, d, w, s, r, o);
    chk("hold_up_done", d, 73);
    run_cmd(OP_RD, 0, 1'b0, 1'b1, d, w, s, r, o);
    chk("hold_rd_done", d, 7);
    chk("hold_rd_nout", o, 6);

    for (int i = 0; i < 16; i++) begin
      run_cmd(2'($urandom_range(0, 3)), 2, 1'b0, 1'b0, d, w, s, r, o);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
